// File: rtl/iq_adc_sample_scheduler_pkg.sv
// Purpose: shared constants for the IQ ADC sample scheduler (FSM encoding, channel ids, default width).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package iq_adc_sample_scheduler_pkg;

    // Scheduler FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Channel identifiers carried on out_ch and in the round-robin pointer
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Default ADC sample width
    localparam int DEF_N = 14;

endpackage

// File: rtl/iq_sample_to_signed.sv
// Purpose: offset-binary ADC code to symmetric two's-complement sample, plus zero-code flag.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of the input.
// Ports: u = unsigned sample in, s = signed sample out, is_zero = u was the all-zeros code.
module iq_sample_to_signed #(
    parameter int N = 14
) (
    input  logic [N-1:0] u,
    output logic [N-1:0] s,
    output logic         is_zero
);

    logic [N-1:0] zero_code;

    // u - 2^(N-1) mod 2^N is just an MSB flip.
    // The zero code maps to -(2^(N-1)-1) instead of the most-negative value,
    // keeping the output range symmetric around zero.
    assign zero_code = {1'b1, {(N-2){1'b0}}, 1'b1};
    assign is_zero   = (u == '0);
    assign s         = is_zero ? zero_code : {~u[N-1], u[N-2:0]};

endmodule

// File: rtl/iq_adc_sample_scheduler.sv
// Purpose: round-robin share of one offset-to-signed converter between I (A) and Q (B) ADC streams.
// Latency: 1 cycle from accepting handshake to registered out_data/out_ch/out_valid.
// Backpressure: a_ready/b_ready drop while the output register is full and out_ready=0, or when disabled.
// Ports: clk/rst (sync active-high), en, ch_mask, cnt_clr; a_*/b_* sample inputs with valid/ready;
//        out_valid/out_data/out_ch/out_ready tagged output; clamp_cnt zero-sample count; busy = not IDLE.
module iq_adc_sample_scheduler
    import iq_adc_sample_scheduler_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       ch_mask,
    input  logic             cnt_clr,
    input  logic             a_valid,
    input  logic [N-1:0]     a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [N-1:0]     b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic             out_ch,
    input  logic             out_ready,
    output logic [CNT_W-1:0] clamp_cnt,
    output logic             busy
);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         last_grant;
    logic         req_a;
    logic         req_b;
    logic         grant_a;
    logic         grant_b;
    logic         load;
    logic         accept;
    logic [N-1:0] mux_dat;
    logic [N-1:0] conv_dat;
    logic         conv_zero;

    assign req_a = a_valid & ch_mask[0];
    assign req_b = b_valid & ch_mask[1];

    // A wins a tie only when B was the last channel served.
    assign grant_a = req_a & (~req_b | (last_grant == CH_B));
    assign grant_b = req_b & ~grant_a;

    // Accept only while running and the output register is empty or draining this cycle.
    assign load    = (state == ST_RUN) & en & (~out_valid | out_ready);
    assign a_ready = load & grant_a;
    assign b_ready = load & grant_b;
    assign accept  = a_ready | b_ready;
    assign busy    = (state != ST_IDLE);

    assign mux_dat = grant_b ? b_data : a_data;

    iq_sample_to_signed #(.N(N)) u_conv (
        .u       (mux_dat),
        .s       (conv_dat),
        .is_zero (conv_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_RUN;
            ST_RUN:   if (!en) state_nxt = (out_valid && !out_ready) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= CH_B;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= CH_A;
            clamp_cnt  <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                last_grant <= grant_b ? CH_B : CH_A;
                out_valid  <= 1'b1;
                out_data   <= conv_dat;
                out_ch     <= grant_b ? CH_B : CH_A;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end

            // Clear beats a same-cycle increment; count sticks at all-ones.
            if (cnt_clr) begin
                clamp_cnt <= '0;
            end else if (accept && conv_zero && (clamp_cnt != '1)) begin
                clamp_cnt <= clamp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iq_adc_sample_scheduler.sv
module tb_iq_adc_sample_scheduler;

    localparam int N     = 14;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       ch_mask;
    logic             cnt_clr;
    logic             a_valid;
    logic [N-1:0]     a_data;
    logic             a_ready;
    logic             b_valid;
    logic [N-1:0]     b_data;
    logic             b_ready;
    logic             out_valid;
    logic [N-1:0]     out_data;
    logic             out_ch;
    logic             out_ready;
    logic [CNT_W-1:0] clamp_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;

    iq_adc_sample_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_mask   (ch_mask),
        .cnt_clr   (cnt_clr),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .clamp_cnt (clamp_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then step 1 time unit off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reset, then bring the scheduler into RUN with outputs idle.
    task automatic restart();
        rst = 1'b1; en = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        cnt_clr = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ch_mask = 2'b11; cnt_clr = 1'b0;
        a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_ch",    out_ch,    0);
        chk("rst_clamp_cnt", clamp_cnt, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_a_ready",   a_ready,   0);
        chk("rst_b_ready",   b_ready,   0);

        // Basic conversion: zero code on A
        en = 1'b1; ch_mask = 2'b11; out_ready = 1'b1;
        tick();
        chk("run_busy", busy, 1);
        a_valid = 1'b1; a_data = 14'h0000;
        #1;
        chk("basic_a_ready", a_ready, 1);
        chk("basic_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        chk("basic_out_valid", out_valid, 1);
        chk("basic_out_data",  out_data,  14'h2001);
        chk("basic_out_ch",    out_ch,    0);
        chk("basic_clamp_cnt", clamp_cnt, 1);
        tick();
        chk("basic_out_empty", out_valid, 0);

        // Round-robin fairness from a fresh reset: A,B,A,B at full rate
        restart();
        a_valid = 1'b1; a_data = 14'h2000;
        b_valid = 1'b1; b_data = 14'h3FFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            chk("rr_out_valid", out_valid, 1);
            chk("rr_out_ch",    out_ch,    (i % 2 == 0) ? 0 : 1);
            chk("rr_out_data",  out_data,  (i % 2 == 0) ? 14'h0000 : 14'h1FFF);
        end

        // Backpressure: hold B sample for 3 cycles, then resume with A then B
        out_ready = 1'b0;
        #1;
        chk("bp_a_ready0", a_ready, 0);
        chk("bp_b_ready0", b_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_ready", b_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_ch",    out_ch,    1);
            chk("bp_out_data",  out_data,  14'h1FFF);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_a_ready", a_ready, 1);
        tick();
        chk("bp_resume_ch0",   out_ch,   0);
        chk("bp_resume_data0", out_data, 14'h0000);
        chk("bp_resume_b_ready", b_ready, 1);
        tick();
        chk("bp_resume_ch1",   out_ch,   1);
        chk("bp_resume_data1", out_data, 14'h1FFF);

        // Disable with held output: DRAIN, en re-assert ignored, then IDLE
        out_ready = 1'b0; en = 1'b0;
        #1;
        chk("dr_a_ready_en0", a_ready, 0);
        tick();
        chk("dr_busy",      busy,      1);
        chk("dr_out_valid", out_valid, 1);
        en = 1'b1;
        #1;
        chk("dr_no_accept_a", a_ready, 0);
        chk("dr_no_accept_b", b_ready, 0);
        tick();
        chk("dr_busy_en1", busy,   1);
        chk("dr_held_ch",  out_ch, 1);
        en = 1'b0; out_ready = 1'b1;
        tick();
        chk("dr_out_valid_done", out_valid, 0);
        chk("dr_busy_done",      busy,      0);

        // Masking: only A eligible, B never sees ready
        restart();
        ch_mask = 2'b01;
        a_valid = 1'b1; a_data = 14'h0000;
        b_valid = 1'b1; b_data = 14'h0005;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mask_a_ready", a_ready, 1);
            chk("mask_b_ready", b_ready, 0);
            tick();
            chk("mask_out_ch", out_ch, 0);
        end
        chk("mask_clamp_cnt", clamp_cnt, 4);

        // Counter saturation with 2^CNT_W+5 more zero samples
        for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
        chk("sat_clamp_cnt", clamp_cnt, 16'hFFFF);

        // Clear wins over same-cycle zero-sample increment
        cnt_clr = 1'b1;
        #1;
        chk("clr_a_ready", a_ready, 1);
        tick();
        chk("clr_clamp_cnt", clamp_cnt, 0);
        cnt_clr = 1'b0;
        tick();
        chk("clr_then_inc", clamp_cnt, 1);

        // Reset mid-operation with a held output; last grant was A
        ch_mask = 2'b11;
        a_data = 14'h0001; b_data = 14'h1234;
        out_ready = 1'b0;
        #1;
        chk("mr_pre_out_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("mr_out_valid",  out_valid, 0);
        chk("mr_out_data",   out_data,  0);
        chk("mr_clamp_cnt",  clamp_cnt, 0);
        chk("mr_busy",       busy,      0);
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        tick();
        #1;
        chk("mr_first_a_ready", a_ready, 1);
        chk("mr_first_b_ready", b_ready, 0);
        tick();
        chk("mr_out_ch_a",   out_ch,   0);
        chk("mr_out_data_a", out_data, 14'h2001);
        chk("mr_clamp_nz",   clamp_cnt, 0);
        tick();
        chk("mr_out_ch_b",   out_ch,   1);
        chk("mr_out_data_b", out_data, 14'h3234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
